// File: rtl/phase_sequencer_pkg.sv
// Shared state encoding and stage-index helpers for the phase sequencer.
package phase_sequencer_pkg;

    localparam int MAX_STAGES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic       wrapped;
        logic [2:0] index;
    } next_t;

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Next non-skipped stage after s, searched cyclically over n stages.
    // Starting from s = n-1 yields the lowest non-skipped stage.
    function automatic next_t next_index(input logic [MAX_STAGES-1:0] mask,
                                         input logic [2:0]            s,
                                         input logic [3:0]            n);
        next_t      r;
        logic [3:0] pos;
        logic       wrap;
        r = '0;
        for (int k = 1; k <= MAX_STAGES; k++) begin
            pos  = {1'b0, s} + 4'(k);
            wrap = (pos >= n);
            if (wrap) pos = pos - n;
            if (!r.found && (4'(k) <= n) && !mask[pos[2:0]]) begin
                r.found   = 1'b1;
                r.wrapped = wrap;
                r.index   = pos[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/phase_sequencer_watchdog.sv
// Per-stage watchdog: counts unpaused WAIT cycles and flags expiry at TMO_CYC-1.
module seq_watchdog #(
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 200
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic active,
    output logic expire
);

    localparam bit               ENABLED = (TMO_CYC != 0);
    localparam logic [TMO_W-1:0] LIMIT   = ENABLED ? TMO_W'(TMO_CYC - 1) : '0;

    logic [TMO_W-1:0] count_q;

    // NOTE: reset is synchronous, so it is simply the highest-priority branch at the clock edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear) begin
            count_q <= '0;
        end else if (active && (count_q != '1)) begin
            count_q <= count_q + TMO_W'(1);
        end
    end

    assign expire = ENABLED && active && (count_q == LIMIT);

endmodule

// File: rtl/phase_sequencer.sv
// Round-robin controller driving N handshaked stages with skip, pause, single-pass and watchdog.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int  N_STAGES = 3,
    parameter int  TMO_W    = 8,
    parameter int  TMO_CYC  = 200,
    localparam int IDX_W    = idx_width(N_STAGES)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                run_i,
    input  logic                single_i,
    input  logic                pause_i,
    input  logic [N_STAGES-1:0] skip_mask_i,
    input  logic [N_STAGES-1:0] done_i,
    input  logic                clr_err_i,
    output logic [N_STAGES-1:0] en_o,
    output logic [IDX_W-1:0]    stage_o,
    output logic                busy_o,
    output logic                frame_o,
    output logic                timeout_o,
    output logic [IDX_W-1:0]    err_stage_o
);

    state_t              state_q, state_d;
    logic [N_STAGES-1:0] en_q, en_d;
    logic [IDX_W-1:0]    stage_q, stage_d;
    logic                timeout_q, timeout_d;
    logic [IDX_W-1:0]    err_q, err_d;
    logic                frame_c;
    logic                wd_clear, wd_active, wd_expire;
    logic [2:0]          search_from;
    next_t               nx;

    // From IDLE the search starts at the last stage so it lands on the lowest non-skipped one.
    assign search_from = (state_q == GAP) ? 3'(stage_q) : 3'(N_STAGES - 1);
    assign nx          = next_index(MAX_STAGES'(skip_mask_i), search_from, 4'(N_STAGES));
    assign wd_active   = (state_q == WAIT) && !pause_i;

    seq_watchdog #(
        .TMO_W  (TMO_W),
        .TMO_CYC(TMO_CYC)
    ) u_watchdog (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clear (wd_clear),
        .active(wd_active),
        .expire(wd_expire)
    );

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        stage_d   = stage_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        frame_c   = 1'b0;
        wd_clear  = 1'b0;

        if (clr_err_i) begin
            timeout_d = 1'b0;
            err_d     = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (run_i && nx.found) begin
                    en_d     = N_STAGES'(1) << nx.index;
                    stage_d  = IDX_W'(nx.index);
                    wd_clear = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (done_i[stage_q]) begin
                    en_d    = '0;
                    state_d = GAP;
                end else if (wd_expire) begin
                    en_d      = '0;
                    timeout_d = 1'b1;
                    err_d     = stage_q;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (!pause_i) begin
                    frame_c = !nx.found || nx.wrapped;
                    if (nx.found && !(frame_c && (single_i || !run_i))) begin
                        en_d     = N_STAGES'(1) << nx.index;
                        stage_d  = IDX_W'(nx.index);
                        wd_clear = 1'b1;
                        state_d  = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            en_q      <= '0;
            stage_q   <= '0;
            timeout_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            stage_q   <= stage_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign en_o        = en_q;
    assign stage_o     = stage_q;
    assign busy_o      = (state_q != IDLE);
    assign frame_o     = frame_c;
    assign timeout_o   = timeout_q;
    assign err_stage_o = err_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized scoreboard bench: a pass-level reference model predicts every cycle's outputs.
module tb_phase_sequencer;

    localparam int N   = 3;
    localparam int TMO = 5;
    localparam int IW  = 2;

    typedef struct packed {
        logic [N-1:0]  en;
        logic [IW-1:0] stage;
        logic          busy;
        logic          frame;
        logic          timeout;
        logic [IW-1:0] err;
    } snap_t;

    logic          clk_i = 1'b0;
    logic          rst_ni, run_i, single_i, pause_i, clr_err_i;
    logic [N-1:0]  skip_mask_i, done_i, en_o;
    logic [IW-1:0] stage_o, err_stage_o;
    logic          busy_o, frame_o, timeout_o;

    always #5 clk_i = ~clk_i;

    phase_sequencer #(
        .N_STAGES(N),
        .TMO_W   (8),
        .TMO_CYC (TMO)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .run_i      (run_i),
        .single_i   (single_i),
        .pause_i    (pause_i),
        .skip_mask_i(skip_mask_i),
        .done_i     (done_i),
        .clr_err_i  (clr_err_i),
        .en_o       (en_o),
        .stage_o    (stage_o),
        .busy_o     (busy_o),
        .frame_o    (frame_o),
        .timeout_o  (timeout_o),
        .err_stage_o(err_stage_o)
    );

    // Stimulus knobs
    int           k_run_pct, k_pause_pct, k_clr_pct, k_rst_pct, k_mask_pct, k_dmin, k_dmax;
    bit           k_single, k_noise;
    logic [N-1:0] k_mask, k_hang;

    // Reference model: active stage (-1 = none), between-stages flag, last issued, wait age
    int m_active = -1, m_last = 0, m_age = 0, m_err = 0;
    bit m_gap = 0, m_timeout = 0;
    int since = 0, delay = 1000;

    snap_t exp_q[$];
    int    n_checks = 0, n_pass = 0, cyc = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    function automatic bit chance(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    function automatic int lowest_above(input logic [N-1:0] mask, input int s);
        for (int j = s + 1; j < N; j++)
            if (!mask[j]) return j;
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sampled there.
    task automatic model_step();
        int nxt;
        nxt = -1;
        if (!rst_ni) begin
            m_active = -1; m_gap = 0; m_last = 0; m_age = 0; m_timeout = 0; m_err = 0;
        end else begin
            if (clr_err_i) begin
                m_timeout = 0;
                m_err     = 0;
            end
            if (m_active >= 0) begin
                if (done_i[m_active]) begin
                    m_active = -1; m_gap = 1;
                end else if (TMO != 0 && !pause_i && m_age == TMO - 1) begin
                    m_timeout = 1; m_err = m_active; m_active = -1; m_gap = 1;
                end else if (!pause_i) begin
                    m_age++;
                end
            end else if (m_gap) begin
                if (!pause_i) begin
                    m_gap = 0;
                    nxt = lowest_above(skip_mask_i, m_last);
                    if (nxt < 0 && !single_i && run_i) nxt = lowest_above(skip_mask_i, -1);
                end
            end else if (run_i) begin
                nxt = lowest_above(skip_mask_i, -1);
            end
            if (nxt >= 0) begin
                m_active = nxt; m_last = nxt; m_age = 0;
            end
        end
        if (nxt >= 0) begin
            since = 0;
            delay = k_hang[nxt] ? 100000 : int'($urandom_range(k_dmax, k_dmin));
        end else begin
            since++;
        end
    endtask

    task automatic drive();
        rst_ni      = !chance(k_rst_pct);
        run_i       = chance(k_run_pct);
        single_i    = k_single;
        pause_i     = chance(k_pause_pct);
        clr_err_i   = chance(k_clr_pct);
        skip_mask_i = chance(k_mask_pct) ? N'($urandom) : k_mask;
        done_i      = k_noise ? N'($urandom) : '0;
        if (m_active >= 0) done_i[m_active] = (since >= delay - 1);
    endtask

    task automatic tick();
        snap_t e;
        @(posedge clk_i);
        model_step();
        #1;
        cyc++;
        drive();
        e.en      = (m_active >= 0) ? N'(1 << m_active) : '0;
        e.stage   = IW'(m_last);
        e.busy    = (m_active >= 0) || m_gap;
        e.frame   = m_gap && !pause_i && (lowest_above(skip_mask_i, m_last) < 0);
        e.timeout = m_timeout;
        e.err     = IW'(m_err);
        exp_q.push_back(e);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic set_defaults();
        k_run_pct = 0; k_pause_pct = 0; k_clr_pct = 0; k_rst_pct = 0; k_mask_pct = 0;
        k_dmin = 3; k_dmax = 3; k_single = 0; k_noise = 0; k_mask = '0; k_hang = '0;
    endtask

    // Monitor: every cycle the DUT presents a full output set, compared against the queue head.
    always @(negedge clk_i) begin
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("en_o",        8'(en_o),        8'(e.en));
            check("stage_o",     8'(stage_o),     8'(e.stage));
            check("busy_o",      8'(busy_o),      8'(e.busy));
            check("frame_o",     8'(frame_o),     8'(e.frame));
            check("timeout_o",   8'(timeout_o),   8'(e.timeout));
            check("err_stage_o", 8'(err_stage_o), 8'(e.err));
            check("en_onehot",   8'($countones(en_o) <= 1), 8'(1));
        end
    end

    initial begin
        rst_ni = 1'b0; run_i = 1'b0; single_i = 1'b0; pause_i = 1'b0; clr_err_i = 1'b0;
        skip_mask_i = '0; done_i = '0;
        set_defaults();

        k_rst_pct = 100; run_cycles(3);

        // Basic free-run, done three cycles after each enable
        set_defaults(); k_run_pct = 100; run_cycles(30);
        k_run_pct = 0; run_cycles(16);

        // Skip stage 1, single pass from a one-cycle run pulse
        k_mask = 3'b010; k_single = 1; k_run_pct = 100; run_cycles(1);
        k_run_pct = 0; run_cycles(14);

        // Stage 1 hangs: watchdog expiry, then error clear
        set_defaults(); k_hang = 3'b010; k_run_pct = 100; run_cycles(25);
        k_run_pct = 0; run_cycles(15);
        k_clr_pct = 100; run_cycles(1);
        k_clr_pct = 0; run_cycles(3);

        // Pause while waiting on a hung stage, then pause across a gap
        set_defaults(); k_hang = 3'b111; k_run_pct = 100; run_cycles(2);
        k_pause_pct = 100; run_cycles(20);
        k_pause_pct = 0; k_hang = '0; run_cycles(12);
        k_pause_pct = 100; run_cycles(8);
        k_pause_pct = 0; run_cycles(6);

        // Done lands on the expiry cycle
        k_dmin = 5; k_dmax = 5; run_cycles(30);

        // Reset in the middle of a stage
        k_dmin = 3; k_dmax = 3; run_cycles(6);
        k_rst_pct = 100; run_cycles(1);
        k_rst_pct = 0; k_run_pct = 0; run_cycles(4);

        // Every stage skipped from IDLE
        k_mask = 3'b111; k_run_pct = 100; run_cycles(15);

        // Randomized segments
        for (int seg = 0; seg < 40; seg++) begin
            k_run_pct   = int'($urandom_range(100, 50));
            k_pause_pct = int'($urandom_range(30, 0));
            k_clr_pct   = int'($urandom_range(10, 0));
            k_rst_pct   = int'($urandom_range(2, 0));
            k_mask_pct  = int'($urandom_range(20, 0));
            k_mask      = N'($urandom);
            k_single    = 1'($urandom);
            k_noise     = 1'b1;
            k_dmin      = 1;
            k_dmax      = 7;
            k_hang      = ($urandom_range(3) == 0) ? N'(1 << $urandom_range(N - 1)) : '0;
            run_cycles(50);
        end

        @(negedge clk_i);
        #1;
        check("scoreboard_drained", 8'(exp_q.size()), 8'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
